// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - byte-stream to 32-bit instruction memory loader
//
// Purpose:
//   Accepts an instruction image as a stream of bytes (little-endian within
//   each 32-bit word), packs them into words and issues one write per word to
//   an instruction memory write port. A final partial word is zero-padded.
//   Bytes arriving after the memory is full are discarded and flag an error.
//
// Ports:
//   clock, reset     single clock, asynchronous active-high reset
//   start            one-cycle request to begin a load (ignored while loading)
//   in_valid/in_data/in_last/in_ready
//                    byte stream handshake; transfer when in_valid && in_ready
//   wr_en/wr_addr/wr_data
//                    one-cycle write strobe, byte address and assembled word;
//                    address/data hold their last values between writes
//   busy, done       state indicators (LOAD, DONE)
//   error            sticky overflow flag, cleared by the next start
//   word_count       words written in the current load

module instruction_loader #(
  parameter int SIZE = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic                   wr_en,
  output logic [31:0]            wr_addr,
  output logic [31:0]            wr_data,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [$clog2(SIZE):0]  word_count
);

  localparam int WCW = $clog2(SIZE) + 1;
  localparam logic [WCW-1:0] SIZE_W = WCW'(SIZE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       lane_q, lane_d;
  // Only bytes 0..2 need holding; byte 3 goes straight into the write word.
  logic [23:0]      asm_q, asm_d;
  logic [WCW-1:0]   wc_q, wc_d;
  logic             err_q, err_d;
  logic             wr_en_q, wr_en_d;
  logic [31:0]      wr_addr_q, wr_addr_d;
  logic [31:0]      wr_data_q, wr_data_d;

  logic             accept;
  logic [31:0]      word_c;

  assign accept = (state_q == S_LOAD) && in_valid;

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    asm_d     = asm_q;
    wc_d      = wc_q;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    // Current partial word with the incoming byte dropped into its lane.
    // Unfilled upper lanes are zero because asm is cleared at every word start.
    word_c = {8'h00, asm_q};
    word_c[{lane_q, 3'b000} +: 8] = in_data;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          lane_d  = 2'd0;
          asm_d   = 24'h0;
          wc_d    = '0;
          err_d   = 1'b0;
        end
      end

      S_LOAD: begin
        if (accept) begin
          if (wc_q == SIZE_W) begin
            // Memory already full: drop the byte and stop.
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if ((lane_q == 2'd3) || in_last) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {{(32 - WCW - 2){1'b0}}, wc_q, 2'b00};
            wr_data_d = word_c;
            wc_d      = wc_q + 1'b1;
            lane_d    = 2'd0;
            asm_d     = 24'h0;
            if (in_last) begin
              state_d = S_DONE;
            end
          end else begin
            lane_d = lane_q + 2'd1;
            asm_d  = word_c[23:0];
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      lane_q    <= 2'd0;
      asm_q     <= 24'h0;
      wc_q      <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 32'h0;
      wr_data_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      asm_q     <= asm_d;
      wc_q      <= wc_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Status outputs decode straight from the state register.
  assign in_ready   = (state_q == S_LOAD);
  assign busy       = (state_q == S_LOAD);
  assign done       = (state_q == S_DONE);
  assign error      = err_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - testbench for instruction_loader

module tb_instruction_loader;

  logic        clock;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  word_count;

  instruction_loader #(.SIZE(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        start;
    logic        valid;
    logic [7:0]  data;
    logic        last;
    logic        e_ready;
    logic        e_wr_en;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic [2:0]  e_wc;
    logic        e_busy;
    logic        e_done;
    logic        e_err;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          acc_at_write[$];
  int          checks;
  int          failures;

  function automatic void add(logic st, logic v, logic [7:0] d, logic l,
                              logic rdy, logic we, logic [31:0] a, logic [31:0] wdat,
                              logic [2:0] wc, logic bz, logic dn, logic er);
    vec_t t;
    t.start = st; t.valid = v; t.data = d; t.last = l;
    t.e_ready = rdy; t.e_wr_en = we; t.e_addr = a; t.e_data = wdat;
    t.e_wc = wc; t.e_busy = bz; t.e_done = dn; t.e_err = er;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Advance one clock edge and sample 1 time unit later; log any write.
  task automatic step();
    @(posedge clock);
    #1;
    if (wr_en === 1'b1) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
    end
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    acc_at_write.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, ".wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, ".wr_addr"}, wr_addr, 32'd0);
    chk({tag, ".wr_data"}, wr_data, 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".error"}, 32'(error), 32'd0);
    chk({tag, ".word_count"}, 32'(word_count), 32'd0);
  endtask

  task automatic feed(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    logic [7:0] img[8];
    int         accepted;
    int         cyc;
    logic       start_poked;
    logic       v;

    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;

    step();
    step();
    chk_reset_outputs("por");
    reset = 1'b0;
    step();
    chk_reset_outputs("idle");

    // start ignored byte traffic in IDLE is covered by the DONE rows below
    add(1,0,8'h00,0, 1,0,32'h0,32'h0,        3'd0,1,0,0);
    add(0,1,8'h13,0, 1,0,32'h0,32'h0,        3'd0,1,0,0);
    add(0,1,8'h00,0, 1,0,32'h0,32'h0,        3'd0,1,0,0);
    add(0,1,8'h00,0, 1,0,32'h0,32'h0,        3'd0,1,0,0);
    add(0,1,8'h00,0, 1,1,32'h0,32'h00000013, 3'd1,1,0,0);
    add(0,1,8'h20,0, 1,0,32'h0,32'h00000013, 3'd1,1,0,0);
    add(0,1,8'h08,0, 1,0,32'h0,32'h00000013, 3'd1,1,0,0);
    add(0,1,8'h00,0, 1,0,32'h0,32'h00000013, 3'd1,1,0,0);
    add(0,1,8'h20,1, 0,1,32'h4,32'h20000820, 3'd2,0,1,0);
    add(0,0,8'h00,0, 0,0,32'h4,32'h20000820, 3'd2,0,1,0);
    add(0,1,8'h77,1, 0,0,32'h4,32'h20000820, 3'd2,0,1,0);
    add(1,0,8'h00,0, 1,0,32'h4,32'h20000820, 3'd0,1,0,0);
    add(0,1,8'hAA,0, 1,0,32'h4,32'h20000820, 3'd0,1,0,0);
    add(0,1,8'hBB,1, 0,1,32'h0,32'h0000BBAA, 3'd1,0,1,0);
    add(0,0,8'h00,0, 0,0,32'h0,32'h0000BBAA, 3'd1,0,1,0);
    add(1,0,8'h00,0, 1,0,32'h0,32'h0000BBAA, 3'd0,1,0,0);
    add(0,1,8'h11,0, 1,0,32'h0,32'h0000BBAA, 3'd0,1,0,0);
    add(0,0,8'h99,0, 1,0,32'h0,32'h0000BBAA, 3'd0,1,0,0);
    add(0,1,8'h22,0, 1,0,32'h0,32'h0000BBAA, 3'd0,1,0,0);
    add(0,1,8'h33,1, 0,1,32'h0,32'h00332211, 3'd1,0,1,0);
    add(1,0,8'h00,0, 1,0,32'h0,32'h00332211, 3'd0,1,0,0);
    add(0,1,8'h5A,1, 0,1,32'h0,32'h0000005A, 3'd1,0,1,0);

    for (int i = 0; i < vecs.size(); i++) begin
      start    = vecs[i].start;
      in_valid = vecs[i].valid;
      in_data  = vecs[i].data;
      in_last  = vecs[i].last;
      step();
      chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].e_ready));
      chk($sformatf("v%0d.wr_en", i), 32'(wr_en), 32'(vecs[i].e_wr_en));
      chk($sformatf("v%0d.wr_addr", i), wr_addr, vecs[i].e_addr);
      chk($sformatf("v%0d.wr_data", i), wr_data, vecs[i].e_data);
      chk($sformatf("v%0d.word_count", i), 32'(word_count), 32'(vecs[i].e_wc));
      chk($sformatf("v%0d.busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d.done", i), 32'(done), 32'(vecs[i].e_done));
      chk($sformatf("v%0d.error", i), 32'(error), 32'(vecs[i].e_err));
    end
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;

    // Overflow: 16 bytes fill the 4-word memory, the 17th must be rejected.
    clear_log();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 16; i++) feed(8'(i), 1'b0);
    chk("ovf.writes", 32'(wa.size()), 32'd4);
    for (int k = 0; k < 4 && k < wa.size(); k++) begin
      chk($sformatf("ovf.addr%0d", k), wa[k], 32'(4 * k));
      chk($sformatf("ovf.data%0d", k), wd[k],
          {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
    end
    step();
    step();
    step();
    chk("full.word_count", 32'(word_count), 32'd4);
    chk("full.busy", 32'(busy), 32'd1);
    chk("full.error", 32'(error), 32'd0);
    chk("full.done", 32'(done), 32'd0);
    feed(8'hEE, 1'b0);
    chk("ovf.error", 32'(error), 32'd1);
    chk("ovf.done", 32'(done), 32'd1);
    chk("ovf.busy", 32'(busy), 32'd0);
    chk("ovf.wr_en", 32'(wr_en), 32'd0);
    step();
    step();
    chk("ovf.no_fifth_write", 32'(wa.size()), 32'd4);
    chk("ovf.error_hold", 32'(error), 32'd1);
    chk("ovf.done_hold", 32'(done), 32'd1);

    // Restart from DONE with error set.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart.error", 32'(error), 32'd0);
    chk("restart.done", 32'(done), 32'd0);
    chk("restart.word_count", 32'(word_count), 32'd0);
    chk("restart.busy", 32'(busy), 32'd1);

    // Throttled stream with a stray start mid-load.
    img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h20, 8'h08, 8'h00, 8'h20};
    clear_log();
    accepted    = 0;
    cyc         = 0;
    start_poked = 1'b0;
    while (accepted < 8 && cyc < 200) begin
      v        = 1'($urandom_range(1, 0));
      in_valid = v;
      in_data  = img[accepted];
      in_last  = (accepted == 7);
      if (accepted == 5 && !start_poked) begin
        start       = 1'b1;
        start_poked = 1'b1;
      end
      step();
      start = 1'b0;
      if (v) accepted++;
      if (wr_en === 1'b1) acc_at_write.push_back(accepted);
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("thr.accepted", 32'(accepted), 32'd8);
    chk("thr.writes", 32'(wa.size()), 32'd2);
    if (wa.size() == 2 && acc_at_write.size() == 2) begin
      chk("thr.first_write_after", 32'(acc_at_write[0]), 32'd4);
      chk("thr.addr0", wa[0], 32'h0);
      chk("thr.data0", wd[0], 32'h00000013);
      chk("thr.addr1", wa[1], 32'h4);
      chk("thr.data1", wd[1], 32'h20000820);
    end
    chk("thr.word_count", 32'(word_count), 32'd2);
    chk("thr.done", 32'(done), 32'd1);
    chk("thr.error", 32'(error), 32'd0);

    // Reset after six accepted bytes abandons the partial second word.
    clear_log();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 6; i++) feed(8'(i), 1'b0);
    chk("rst.pre_writes", 32'(wa.size()), 32'd1);
    reset = 1'b1;
    #1;
    chk_reset_outputs("rst.async");
    @(posedge clock);
    #1;
    reset = 1'b0;
    clear_log();
    step();
    step();
    step();
    chk("rst.no_write", 32'(wa.size()), 32'd0);
    chk_reset_outputs("rst.after");
    start = 1'b1;
    step();
    start = 1'b0;
    feed(8'hA1, 1'b0);
    feed(8'hA2, 1'b0);
    feed(8'hA3, 1'b0);
    feed(8'hA4, 1'b0);
    chk("rst.new_writes", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      chk("rst.new_addr", wa[0], 32'h0);
      chk("rst.new_data", wd[0], 32'hA4A3A2A1);
    end
    chk("rst.new_word_count", 32'(word_count), 32'd1);
    chk("rst.new_busy", 32'(busy), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 The block SHALL have parameter SIZE, default 64, giving the instruction memory depth in 32-bit words.
REQ-002 The block SHALL have port clock, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, a one-cycle request to begin loading an image.
REQ-005 The block SHALL have port in_valid, input, 1 bit, byte source has data.
REQ-006 The block SHALL have port in_data, input, 8 bits, image byte, little-endian within a word.
REQ-007 The block SHALL have port in_last, input, 1 bit, qualifies in_data as the final image byte.
REQ-008 The block SHALL have port in_ready, output, 1 bit, loader accepts a byte this cycle.
REQ-009 The block SHALL have port wr_en, output, 1 bit, one-cycle write strobe to the instruction memory write port.
REQ-010 The block SHALL have port wr_addr, output, 32 bits, byte address of the word being written (word index times 4).
REQ-011 The block SHALL have port wr_data, output, 32 bits, assembled instruction word.
REQ-012 The block SHALL have port busy, output, 1 bit, high in LOAD.
REQ-013 The block SHALL have port done, output, 1 bit, high in DONE.
REQ-014 The block SHALL have port error, output, 1 bit, sticky overflow flag.
REQ-015 The block SHALL have port word_count, output, clog2(SIZE)+1 bits, number of words written this load.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, DONE; start in IDLE or DONE moves to LOAD next edge, clearing word_count, error, byte lane and assembly register; start in LOAD is ignored.
REQ-017 A byte transfer SHALL occur on an edge where in_valid and in_ready are both high; in_ready SHALL equal 1 exactly when in LOAD.
REQ-018 Byte n of a word (n=0..3, counted from word start) SHALL land in wr_data bits [8n+7:8n].
REQ-019 On the edge accepting byte 3, wr_en SHALL go high for exactly the following cycle, with wr_addr = 4*word_count (pre-increment value), wr_data the full word, and word_count incremented on that same edge.
REQ-020 in_ready SHALL remain high while wr_en is high, so back-to-back bytes sustain one byte per cycle (one word per 4 cycles).
REQ-021 If the last byte completes a word, the block SHALL perform the REQ-019 write and enter DONE on the same edge.
REQ-022 If the last byte is byte 0..2, the block SHALL write the partial word zero-padded in the upper unfilled bytes with REQ-019 timing, increment word_count, and enter DONE.
REQ-023 If a byte is accepted while word_count == SIZE, the block SHALL discard it, issue no write, set error, and enter DONE.
REQ-024 Reaching word_count == SIZE without in_last SHALL leave the block in LOAD with no error until another byte arrives.
REQ-025 wr_en SHALL never be high in IDLE except the cycle after a REQ-019/022 write edge; wr_addr/wr_data SHALL hold their last values when wr_en is low.
REQ-026 done and error SHALL hold until the next start or reset.

Reset
REQ-027 While reset is high, asynchronously: state IDLE, in_ready 0, wr_en 0, wr_addr 0, wr_data 0, busy 0, done 0, error 0, word_count 0, byte lane 0.
REQ-028 Reset mid-load SHALL abandon any partial word with no write, and the next load SHALL start at address 0.
REQ-029 The block SHALL NOT clear or otherwise modify previously written memory contents on reset.

Verification
REQ-030 Full words: start, then bytes 0x13,0x00,0x00,0x00,0x20,0x08,0x00,0x20(last) -> writes 0x00000013@0 then 0x20000820@4, word_count 2, done 1, error 0.
REQ-031 Partial tail: start, bytes 0xAA,0xBB(last) -> single write 0x0000BBAA@0, done 1, word_count 1.
REQ-032 Overflow with SIZE=4: start, 17 bytes without last -> 4 writes at 0,4,8,12, 17th byte -> error 1, done 1, no fifth write.
REQ-033 Throttling: in_valid toggled randomly on 8 bytes -> same two words as REQ-030; no write before the 4th accepted byte; start asserted during LOAD has no effect.
REQ-034 Reset after 6 accepted bytes -> no write for bytes 4-5, all outputs at reset values; new start plus 4 bytes -> write to address 0.
REQ-035 Restart from DONE with error set: start -> error 0, done 0, word_count 0, busy 1 next cycle.
